// File: rtl/dram_lsu.sv
// Load/store initiator for the word-wide data DRAM: lane select, extension and sub-word RMW.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses instead of force-aligning them.
module dram_lsu #(
  parameter int         ADDR_W = 14,
  parameter logic [1:0] OP_B   = 2'd0,
  parameter logic [1:0] OP_H   = 2'd1,
  parameter logic [1:0] OP_W   = 2'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_op,
  input  logic              req_uns,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // state  | meaning
  // IDLE   | ready, waiting for a request
  // RD     | DRAM word read (loads and sub-word stores)
  // WR     | single-cycle DRAM write of the merged word
  // DONE   | ack pulse, err qualifies it
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [1:0]        op_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic              rej_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              illegal_in;
  logic              misal_in;
  logic              reject_in;
  logic [1:0]        lane_in;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  always_comb begin
    illegal_in = (req_op == 2'd3);
    misal_in   = ((req_op == OP_H) && req_addr[0]) ||
                 ((req_op == OP_W) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    reject_in  = illegal_in || misal_in;
`else
    reject_in  = illegal_in;
`endif
    // Lane bits below the access size are dropped, which force-aligns when not trapping.
    case (req_op)
      OP_B:    lane_in = req_addr[1:0];
      OP_H:    lane_in = {req_addr[1], 1'b0};
      default: lane_in = 2'b00;
    endcase
  end

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] data,
                                             input logic [1:0]  op,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    if (op == OP_B)
      res[{lane, 3'b000} +: 8] = data[7:0];
    else if (op == OP_H)
      res[{lane[1], 4'b0000} +: 16] = data[15:0];
    else
      res = data;
    return res;
  endfunction

  function automatic logic [31:0] extract_word(input logic [31:0] word,
                                               input logic [1:0]  op,
                                               input logic        uns,
                                               input logic [1:0]  lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    if (op == OP_B)
      res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    else if (op == OP_H)
      res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    else
      res = word;
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (reject_in)
            state_d = S_DONE;
          else if (req_we && (req_op == OP_W))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      op_q        <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      rej_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= req_we;
            op_q    <= req_op;
            uns_q   <= req_uns;
            lane_q  <= lane_in;
            wdata_q <= req_wdata;
            rej_q   <= reject_in;
            if (!reject_in) begin
              mem_addr_q <= req_addr[ADDR_W+1:2];
              if (req_we && (req_op == OP_W))
                mem_wdata_q <= req_wdata;
            end else if (!req_we) begin
              rdata_q <= 32'h0;
            end
          end
        end
        S_RD: begin
          // The old word is merged as it arrives, so WR drives a registered write word.
          if (we_q)
            mem_wdata_q <= merge_word(mem_rdata, wdata_q, op_q, lane_q);
          else
            rdata_q <= extract_word(mem_rdata, op_q, uns_q, lane_q);
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign ack       = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && rej_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Gated by rst so a reset landing on the WR cycle cannot commit a partial RMW.
  assign mem_we    = (state_q == S_WR) && !rst;

endmodule
